// File: rtl/de2_70_ethernet_st_data_format_adapter_32to8_if.sv
// Avalon-ST stream bundle shared by the wide input and byte-wide output sides of the
// 32-to-8 adapter; master drives the payload, slave drives ready.
interface de2_70_ethernet_st_data_format_adapter_32to8_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  data;
  logic               error;
  logic               startofpacket;
  logic               endofpacket;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output valid, data, error, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, data, error, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/de2_70_ethernet_st_data_format_adapter_32to8.sv
// Avalon-ST width down-converter: one 32-bit/4-symbol beat is held and replayed as
// 8-bit symbols, first symbol from the high-order byte, with same-cycle refill.
module de2_70_ethernet_st_data_format_adapter_32to8 #(
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int EMPTY_WIDTH      = 2
) (
  input  logic clk,
  input  logic reset_n,
  de2_70_ethernet_st_data_format_adapter_32to8_if.slave  in_st,
  de2_70_ethernet_st_data_format_adapter_32to8_if.master out_st
);
  localparam int IN_W = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;

  logic                   r_full;
  logic [IN_W-1:0]        r_data;
  logic                   r_err;
  logic                   r_sop;
  logic                   r_eop;
  logic [EMPTY_WIDTH-1:0] r_last_idx;
  logic [EMPTY_WIDTH-1:0] r_idx;

  logic                   w_on_last;
  logic                   w_out_fire;
  logic                   w_in_ready;
  logic                   w_accept;
  logic [EMPTY_WIDTH-1:0] w_new_last;
  logic [IN_W-1:0]        w_shifted;

  assign w_on_last  = (r_idx == r_last_idx);
  assign w_out_fire = r_full && out_st.ready;
  // Ready looks through to out_ready on the final symbol so the next beat lands with no bubble.
  assign w_in_ready = !r_full || (out_st.ready && w_on_last);
  assign w_accept   = in_st.valid && w_in_ready;

  // Index of the final symbol to emit for the beat being offered; empty only matters on eop.
  always_comb begin
    w_new_last = EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1);
    if (in_st.endofpacket) begin
      w_new_last = EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1) - in_st.empty;
    end else begin
      w_new_last = EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1);
    end
  end

  // Bring the current symbol up to the top byte so the output is a fixed slice.
  assign w_shifted = r_data << (BITS_PER_SYMBOL * r_idx);

  assign in_st.ready          = w_in_ready;
  assign out_st.valid         = r_full;
  assign out_st.data          = w_shifted[IN_W-1 -: BITS_PER_SYMBOL];
  assign out_st.error         = r_err;
  assign out_st.startofpacket = r_sop && (r_idx == {EMPTY_WIDTH{1'b0}});
  assign out_st.endofpacket   = r_eop && w_on_last;
  assign out_st.empty         = 1'b0;

  // Holding register and symbol counter: load on accept, step on each output transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full     <= 1'b0;
      r_data     <= {IN_W{1'b0}};
      r_err      <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_last_idx <= {EMPTY_WIDTH{1'b0}};
      r_idx      <= {EMPTY_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_full     <= 1'b1;
      r_data     <= in_st.data;
      r_err      <= in_st.error;
      r_sop      <= in_st.startofpacket;
      r_eop      <= in_st.endofpacket;
      r_last_idx <= w_new_last;
      r_idx      <= {EMPTY_WIDTH{1'b0}};
    end else if (w_out_fire) begin
      if (w_on_last) begin
        r_full <= 1'b0;
        r_idx  <= {EMPTY_WIDTH{1'b0}};
      end else begin
        r_idx  <= r_idx + EMPTY_WIDTH'(1);
      end
    end else begin
      r_full <= r_full;
      r_idx  <= r_idx;
    end
  end
endmodule
